// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit-legality helper used by the counter
// and its digit cells.
package bcd_pkg;
    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell: synchronous load/count/hold, plus a ready flag telling
// the next digit up that this one is about to carry (up) or borrow (down).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             cnt_en,
    input  logic             up,
    output logic [BCD_W-1:0] q,
    output logic             rdy
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= is_bcd(ld_val) ? ld_val : BCD_MIN;
        end else if (cnt_en) begin
            if (up) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            else    q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

    assign rdy = up ? (q == BCD_MAX) : (q == BCD_MIN);
endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with parallel load and a time-multiplexed
// single-digit scan output for the downstream BCD decoder.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int NDIG     = 2,
    parameter int SCAN_DIV = 4,
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [BCD_W*NDIG-1:0] din,
    output logic [BCD_W*NDIG-1:0] q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  err,
    output logic [IW-1:0]         scan_idx,
    output logic [BCD_W-1:0]      scan_bcd
);
    logic [NDIG-1:0]  rdy;
    logic [NDIG-1:0]  cnt_en;
    logic [NDIG-1:0]  bad;
    logic             ripple;
    logic [DW-1:0]    div;
    logic [BCD_W-1:0] digit [NDIG];

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        bcd_digit u_dig (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld     (load),
            .ld_val (din[BCD_W*k +: BCD_W]),
            .cnt_en (cnt_en[k]),
            .up     (up),
            .q      (q[BCD_W*k +: BCD_W]),
            .rdy    (rdy[k])
        );
        assign digit[k] = q[BCD_W*k +: BCD_W];
        assign bad[k]   = !is_bcd(din[BCD_W*k +: BCD_W]);
    end

    // Digit k steps only when every lower digit is at its carry/borrow point;
    // the ripple out of the top digit is the terminal count.
    always_comb begin
        cnt_en = '0;
        ripple = en;
        for (int k = 0; k < NDIG; k++) begin
            cnt_en[k] = ripple;
            ripple    = ripple & rdy[k];
        end
    end

    assign tc = ripple;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            err  <= |bad;
        end else begin
            wrap <= tc;
        end
    end

    // Free-running scan: each digit is presented for SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div      <= '0;
            scan_idx <= '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div      <= '0;
            scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign scan_bcd = digit[scan_idx];
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised and directed bench for bcd_scan_counter (NDIG=2, SCAN_DIV=4)
// against a decimal-arithmetic reference model.
module tb_bcd_scan_counter;
    localparam int NDIG = 2;
    localparam int SDIV = 4;
    localparam int MOD  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] q;
    logic       tc, wrap, err;
    logic [0:0] scan_idx;
    logic [3:0] scan_bcd;

    int checks = 0;
    int failures = 0;

    bcd_scan_counter #(.NDIG(NDIG), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .q(q), .tc(tc), .wrap(wrap), .err(err),
        .scan_idx(scan_idx), .scan_bcd(scan_bcd)
    );

    always #5 clk = ~clk;

    // Reference model: counter held as a plain integer 0..99.
    int m_val = 0;
    int m_cyc = 0;
    bit m_wrap = 0, m_err = 0, m_valid = 0;

    function automatic int dig_ok(input logic [3:0] d);
        return (d > 4'd9) ? 0 : int'(d);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_val <= 0; m_wrap <= 0; m_err <= 0; m_cyc <= 0; m_valid <= 1;
        end else begin
            m_cyc <= m_cyc + 1;
            if (load) begin
                m_val  <= dig_ok(din[7:4]) * 10 + dig_ok(din[3:0]);
                m_err  <= (din[7:4] > 4'd9) || (din[3:0] > 4'd9);
                m_wrap <= 0;
            end else if (en && up) begin
                m_val  <= (m_val + 1) % MOD;
                m_wrap <= (m_val == MOD - 1);
            end else if (en) begin
                m_val  <= (m_val + MOD - 1) % MOD;
                m_wrap <= (m_val == 0);
            end else begin
                m_wrap <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            int idx;
            bit m_tc;
            idx  = (m_cyc / SDIV) % NDIG;
            m_tc = en && ((up && m_val == MOD - 1) || (!up && m_val == 0));
            chk("model_q", 32'(q), 32'(to_bcd(m_val)));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("model_err", 32'(err), 32'(m_err));
            chk("model_tc", 32'(tc), 32'(m_tc));
            chk("model_scan_idx", 32'(scan_idx), 32'(idx));
            chk("model_scan_bcd", 32'(scan_bcd),
                32'(idx == 0 ? m_val % 10 : m_val / 10));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps, tcs;
        logic [0:0] idx_tab [8];
        logic [3:0] bcd_tab [8];
        idx_tab = '{0, 0, 0, 1, 1, 1, 1, 0};
        bcd_tab = '{3, 3, 3, 7, 7, 2, 2, 1};

        // Reset overrides load and en; then a full 00..99..00 up-count.
        rst_n = 0; en = 1; load = 1; din = 8'h57;
        tick(); tick();
        rst_n = 1; load = 0; up = 1;
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_err", 32'(err), 32'h0);
        wraps = 0; tcs = 0;
        for (int i = 0; i < 100; i++) begin
            tcs += int'(tc);
            tick();
            wraps += int'(wrap);
        end
        chk("up_full_q", 32'(q), 32'h00);
        chk("up_wrap_count", 32'(wraps), 32'd1);
        chk("up_tc_count", 32'(tcs), 32'd1);

        // Down roll-over from 01.
        en = 0; load = 1; din = 8'h01;
        tick();
        load = 0; en = 1; up = 0;
        chk("down_q01", 32'(q), 32'h01);
        chk("down_tc01", 32'(tc), 32'h0);
        tick();
        chk("down_q00", 32'(q), 32'h00);
        chk("down_tc00", 32'(tc), 32'h1);
        tick();
        chk("down_q99", 32'(q), 32'h99);
        chk("down_wrap", 32'(wrap), 32'h1);
        tick();
        chk("down_q98", 32'(q), 32'h98);
        chk("down_wrap_clr", 32'(wrap), 32'h0);

        // Illegal digit load, then legal reload, then counting leaves err alone.
        en = 0; load = 1; din = 8'h3C;
        tick();
        chk("bad_load_q", 32'(q), 32'h30);
        chk("bad_load_err", 32'(err), 32'h1);
        load = 0; en = 1; up = 1;
        repeat (5) tick();
        chk("err_sticky", 32'(err), 32'h1);
        en = 0; load = 1; din = 8'h42;
        tick();
        chk("good_load_q", 32'(q), 32'h42);
        chk("good_load_err", 32'(err), 32'h0);

        // Load has priority over en.
        din = 8'h98;
        tick();
        en = 1; up = 1; din = 8'h15;
        tick();
        chk("ld_pri_q", 32'(q), 32'h15);
        chk("ld_pri_wrap", 32'(wrap), 32'h0);
        en = 0; din = 8'h99;
        tick();
        chk("ld99_q", 32'(q), 32'h99);
        chk("ld99_tc", 32'(tc), 32'h0);

        // Scan rotation with a mid-scan reload.
        load = 0; rst_n = 0;
        tick();
        rst_n = 1;
        chk("scan_rst_idx", 32'(scan_idx), 32'h0);
        load = 1; din = 8'h73;
        for (int c = 1; c <= 8; c++) begin
            tick();
            load = (c == 5);
            din  = 8'h21;
            chk($sformatf("scan_idx_c%0d", c), 32'(scan_idx), 32'(idx_tab[c-1]));
            chk($sformatf("scan_bcd_c%0d", c), 32'(scan_bcd), 32'(bcd_tab[c-1]));
        end
        load = 0;

        // Reset in the middle of an up-count with scan_idx=1.
        rst_n = 0;
        tick();
        rst_n = 1; load = 1; din = 8'h43;
        tick();
        load = 0; en = 1; up = 1;
        repeat (4) tick();
        chk("mid_q47", 32'(q), 32'h47);
        chk("mid_idx1", 32'(scan_idx), 32'h1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_rst_q", 32'(q), 32'h00);
        chk("mid_rst_idx", 32'(scan_idx), 32'h0);
        chk("mid_rst_wrap", 32'(wrap), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        tick();
        chk("mid_resume_q", 32'(q), 32'h01);

        // Randomised traffic; direction held for stretches so wraps occur.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) up = ~up;
            case ($urandom_range(0, 3))
                0:       din = 8'h99;
                1:       din = 8'h00;
                default: din = 8'($urandom);
            endcase
            tick();
        end

        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
